// File: rtl/qm_pkg.sv
`default_nettype none
// ============================================================================
// Module : qm_pkg
// Brief  : Shared writeback-stage state encoding and control-field constants.
// Rev    : 1.0
// ============================================================================
package qm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD_WAIT = 2'd1,
      ST_WRITE     = 2'd2
   } qm_state_t;

   localparam logic QM_WSRC_ALU = 1'b0;
   localparam logic QM_WSRC_MEM = 1'b1;
   localparam logic QM_DEST_RT  = 1'b0;
   localparam logic QM_DEST_RD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/qm_writeback.sv
`default_nettype none
// ============================================================================
// Module : qm_writeback
// Brief  : Pipeline writeback stage; drives the register-file write port.
// Rev    : 1.0
// ============================================================================
module qm_writeback
   import qm_pkg::*;
#(
   parameter int RETIRE_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    ci_Valid,
   input  logic                    ci_RegWrite,
   input  logic                    ci_RegWSource,
   input  logic                    ci_RegDest,
   input  logic [31:0]             di_ALUResult,
   input  logic [4:0]              di_RT,
   input  logic [4:0]              di_RD,
   input  logic [31:0]             di_MemData,
   input  logic                    i_MemAck,
   output logic [4:0]              do_WA,
   output logic                    do_WE,
   output logic [31:0]             do_WD,
   output logic                    o_Stall,
   output logic [RETIRE_WIDTH-1:0] o_Retired
);

   qm_state_t               r_state;
   qm_state_t               w_next_state;
   logic                    w_accept;
   logic [4:0]              w_dest;
   logic                    r_regwrite;
   logic [4:0]              r_pend_wa;
   logic [4:0]              r_wa;
   logic [31:0]             r_wd;
   logic [RETIRE_WIDTH-1:0] r_retired;

   assign w_accept = ci_Valid && (r_state != ST_LOAD_WAIT);
   assign w_dest   = (ci_RegDest == QM_DEST_RD) ? di_RD : di_RT;

   always_comb begin
      w_next_state = ST_IDLE;
      if (r_state == ST_LOAD_WAIT) begin
         w_next_state = i_MemAck ? ST_WRITE : ST_LOAD_WAIT;
      end else if (w_accept) begin
         w_next_state = (ci_RegWSource == QM_WSRC_MEM) ? ST_LOAD_WAIT : ST_WRITE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Output address/data registers change only on edges entering WRITE, so a
   // load parks its destination in r_pend_wa until the data returns.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_regwrite <= 1'b0;
         r_pend_wa  <= 5'd0;
         r_wa       <= 5'd0;
         r_wd       <= 32'd0;
      end else if (w_accept) begin
         r_regwrite <= ci_RegWrite;
         if (ci_RegWSource == QM_WSRC_ALU) begin
            r_wa <= w_dest;
            r_wd <= di_ALUResult;
         end else begin
            r_pend_wa <= w_dest;
         end
      end else if ((r_state == ST_LOAD_WAIT) && i_MemAck) begin
         r_wa <= r_pend_wa;
         r_wd <= di_MemData;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_retired <= '0;
      end else if (r_state == ST_WRITE) begin
         r_retired <= r_retired + {{(RETIRE_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign do_WA     = r_wa;
   assign do_WD     = r_wd;
   assign do_WE     = (r_state == ST_WRITE) && r_regwrite && (r_wa != 5'd0);
   assign o_Stall   = (r_state == ST_LOAD_WAIT);
   assign o_Retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_qm_writeback.sv
`default_nettype none
// ============================================================================
// Module : tb_qm_writeback
// Brief  : Directed vector bench for qm_writeback (4-bit retire counter).
// Rev    : 1.0
// ============================================================================
module tb_qm_writeback;

   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          ci_Valid, ci_RegWrite, ci_RegWSource, ci_RegDest;
   logic [31:0]   di_ALUResult, di_MemData;
   logic [4:0]    di_RT, di_RD;
   logic          i_MemAck;
   logic [4:0]    do_WA;
   logic          do_WE;
   logic [31:0]   do_WD;
   logic          o_Stall;
   logic [RW-1:0] o_Retired;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   qm_writeback #(.RETIRE_WIDTH(RW)) dut (
      .clk(clk), .reset_n(reset_n),
      .ci_Valid(ci_Valid), .ci_RegWrite(ci_RegWrite),
      .ci_RegWSource(ci_RegWSource), .ci_RegDest(ci_RegDest),
      .di_ALUResult(di_ALUResult), .di_RT(di_RT), .di_RD(di_RD),
      .di_MemData(di_MemData), .i_MemAck(i_MemAck),
      .do_WA(do_WA), .do_WE(do_WE), .do_WD(do_WD),
      .o_Stall(o_Stall), .o_Retired(o_Retired)
   );

   typedef struct {
      logic        valid, rw, src, dest;
      logic [4:0]  rt, rd;
      logic [31:0] alu, mem;
      logic        ack;
      logic        e_we;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
      logic        e_stall;
      logic [3:0]  e_ret;
   } vec_t;

   vec_t vecs[22];

   function automatic vec_t mk(input logic v, rw, src, dest,
                               input logic [4:0] rt, rd,
                               input logic [31:0] alu, mem,
                               input logic ack, we,
                               input logic [4:0] wa,
                               input logic [31:0] wd,
                               input logic st,
                               input logic [3:0] ret);
      vec_t t;
      t.valid = v; t.rw = rw; t.src = src; t.dest = dest;
      t.rt = rt; t.rd = rd; t.alu = alu; t.mem = mem; t.ack = ack;
      t.e_we = we; t.e_wa = wa; t.e_wd = wd; t.e_stall = st; t.e_ret = ret;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input logic v, rw, src, dest, input logic [4:0] rt, rd,
                        input logic [31:0] alu, mem, input logic ack);
      ci_Valid = v; ci_RegWrite = rw; ci_RegWSource = src; ci_RegDest = dest;
      di_RT = rt; di_RD = rd; di_ALUResult = alu; di_MemData = mem; i_MemAck = ack;
   endtask

   task automatic check_all(input string tag, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic st, input logic [3:0] ret);
      check({tag, ".we"},    32'(do_WE),     32'(we));
      check({tag, ".wa"},    32'(do_WA),     32'(wa));
      check({tag, ".wd"},    do_WD,          wd);
      check({tag, ".stall"}, 32'(o_Stall),   32'(st));
      check({tag, ".ret"},   32'(o_Retired), 32'(ret));
   endtask

   initial begin
      vecs[0]  = mk(1,1,0,1, 5'd0,5'd5, 32'hDEADBEEF,0,0, 1,5'd5,32'hDEADBEEF,0,4'd0);
      vecs[1]  = mk(0,0,0,0, 0,0, 0,0,0,            0,5'd5,32'hDEADBEEF,0,4'd1);
      for (int i = 1; i <= 4; i++)
         vecs[i+1] = mk(1,1,0,0, 5'(i),5'd0, 32'h0F + 32'(i),0,0,
                        1,5'(i),32'h0F + 32'(i),0,4'(i));
      vecs[6]  = mk(0,0,0,0, 0,0, 0,0,0,                 0,5'd4,32'h13,0,4'd5);
      vecs[7]  = mk(1,1,1,0, 5'd9,0, 32'hAAAA,0,0,        0,5'd4,32'h13,1,4'd5);
      vecs[8]  = mk(1,1,0,0, 5'd7,0, 32'h77,0,0,          0,5'd4,32'h13,1,4'd5);
      vecs[9]  = mk(1,1,0,0, 5'd7,0, 32'h77,0,0,          0,5'd4,32'h13,1,4'd5);
      vecs[10] = mk(1,1,0,0, 5'd7,0, 32'h77,32'h12345678,1, 1,5'd9,32'h12345678,0,4'd5);
      vecs[11] = mk(1,1,0,0, 5'd7,0, 32'h77,0,0,          1,5'd7,32'h77,0,4'd6);
      vecs[12] = mk(0,0,0,0, 0,0, 0,32'hDEAD,1,           0,5'd7,32'h77,0,4'd7);
      vecs[13] = mk(1,1,0,0, 5'd0,5'd8, 32'hFFFFFFFF,0,0, 0,5'd0,32'hFFFFFFFF,0,4'd7);
      vecs[14] = mk(0,0,0,0, 0,0, 0,0,0,                 0,5'd0,32'hFFFFFFFF,0,4'd8);
      vecs[15] = mk(1,0,1,0, 5'd3,0, 32'h1,0,0,           0,5'd0,32'hFFFFFFFF,1,4'd8);
      vecs[16] = mk(0,0,0,0, 0,0, 0,32'h55,1,             0,5'd3,32'h55,0,4'd8);
      vecs[17] = mk(0,0,0,0, 0,0, 0,0,0,                 0,5'd3,32'h55,0,4'd9);
      vecs[18] = mk(0,0,0,0, 0,0, 0,32'h99,1,             0,5'd3,32'h55,0,4'd9);
      vecs[19] = mk(1,1,1,1, 5'd2,5'd6, 32'h2,32'h99,1,   0,5'd3,32'h55,1,4'd9);
      vecs[20] = mk(0,0,0,0, 0,0, 0,32'h66,1,             1,5'd6,32'h66,0,4'd9);
      vecs[21] = mk(0,0,0,0, 0,0, 0,0,0,                 0,5'd6,32'h66,0,4'd10);

      // Reset held with random inputs
      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               5'($urandom), 5'($urandom), $urandom, $urandom, 1'($urandom));
         @(posedge clk); #1;
      end
      check_all("reset", 0, 5'd0, 32'd0, 0, 4'd0);
      @(negedge clk);
      drive(0,0,0,0, 0,0, 0,0,0);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("post_reset.we",  32'(do_WE),     32'd0);
         check("post_reset.ret", 32'(o_Retired), 32'd0);
      end

      // Table-driven directed sequence
      for (int i = 0; i < 22; i++) begin
         drive(vecs[i].valid, vecs[i].rw, vecs[i].src, vecs[i].dest,
               vecs[i].rt, vecs[i].rd, vecs[i].alu, vecs[i].mem, vecs[i].ack);
         @(posedge clk); #1;
         check_all($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_wa,
                   vecs[i].e_wd, vecs[i].e_stall, vecs[i].e_ret);
      end

      // Reset during LOAD_WAIT, then a late ack
      drive(1,1,1,0, 5'd11,0, 0,0,0);
      @(posedge clk); #1;
      check("midload.stall", 32'(o_Stall), 32'd1);
      drive(0,0,0,0, 0,0, 0,0,0);
      #2 reset_n = 1'b0;
      #1;
      check_all("midload_rst", 0, 5'd0, 32'd0, 0, 4'd0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(0,0,0,0, 0,0, 0,32'hBAD0BAD0,1);
      @(posedge clk); #1;
      check_all("late_ack", 0, 5'd0, 32'd0, 0, 4'd0);
      drive(0,0,0,0, 0,0, 0,0,0);
      @(posedge clk); #1;
      check_all("late_ack2", 0, 5'd0, 32'd0, 0, 4'd0);

      // Counter wrap: 16 back-to-back ops on a 4-bit counter
      for (int i = 0; i < 16; i++) begin
         drive(1,1,0,0, 5'd1,0, 32'(i),0,0);
         @(posedge clk); #1;
         check($sformatf("wrap%0d.we", i),  32'(do_WE),     32'd1);
         check($sformatf("wrap%0d.ret", i), 32'(o_Retired), 32'(i));
      end
      drive(0,0,0,0, 0,0, 0,0,0);
      @(posedge clk); #1;
      check("wrap.final_ret", 32'(o_Retired), 32'd0);
      check("wrap.final_we",  32'(do_WE),     32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/qm_writeback.md
# qm_writeback

Final stage of the q3kmips five-stage pipeline. Captures the retiring instruction from the memory stage and selects its destination register (RT or RD) and its result (ALU result or data-memory read data). It drives the register-file write port (WA/WE/WD) that the decode stage consumes. Loads hold the stage until the data memory acknowledges, and the stage back-pressures the upstream pipeline while it waits.

## Interface
Parameters:
- RETIRE_WIDTH, 32, width of the retired-instruction counter

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ci_Valid  in  1  memory stage presents a real instruction this cycle
- ci_RegWrite  in  1  instruction writes a register
- ci_RegWSource  in  1  0 = ALU result, 1 = data-memory read data (load)
- ci_RegDest  in  1  0 = destination is RT, 1 = destination is RD
- di_ALUResult  in  32  ALU result from the memory stage
- di_RT  in  5  RT field of the instruction
- di_RD  in  5  RD field of the instruction
- di_MemData  in  32  data-memory read data, qualified by i_MemAck
- i_MemAck  in  1  data memory returns read data this cycle
- do_WA  out  5  register-file write address (to decode di_WA)
- do_WE  out  1  register-file write enable (to decode di_WE)
- do_WD  out  32  register-file write data (to decode di_WD)
- o_Stall  out  1  writeback cannot accept; upstream must hold
- o_Retired  out  RETIRE_WIDTH  count of instructions retired since reset

## Operation
- States: IDLE (empty), LOAD_WAIT (load captured, data not yet returned), WRITE (result ready, write-port cycle).
- Accept condition: ci_Valid && !o_Stall, sampled at the rising edge. On accept:
  - Latch wa = ci_RegDest ? di_RD : di_RT.
  - Latch RegWrite, RegWSource and di_ALUResult.
  - Next state is LOAD_WAIT if RegWSource = 1, else WRITE.
- No accept: state becomes IDLE, except that LOAD_WAIT persists until ack.
- LOAD_WAIT: when i_MemAck = 1 at an edge, latch di_MemData as the result and go to WRITE. i_MemAck in any other state is ignored.
- WRITE lasts exactly one cycle. A new instruction may be accepted at the edge ending WRITE, giving back-to-back ALU retirement at one instruction per cycle.
- do_WE = (state == WRITE) && RegWrite && (wa != 0). Writes to $0 are always suppressed.
- do_WA / do_WD: the latched wa and result. Both are valid whenever state == WRITE and are don't-care otherwise, but must not toggle outside WRITE.
- o_Stall = (state == LOAD_WAIT), combinational from state.
- o_Retired increments by 1 at every edge ending a WRITE cycle, regardless of RegWrite or wa. It wraps from 2^RETIRE_WIDTH-1 to 0.
- A load with RegWrite = 0 still waits for ack, retires and counts.

## Timing
- Reset (async assert, sync release): state IDLE, do_WE 0, do_WA 0, do_WD 0, o_Stall 0, o_Retired 0. All latched fields are cleared.
- Reset asserted in LOAD_WAIT or WRITE: the pending write is dropped with no WE pulse. An ack arriving after reset is ignored.
- ALU op: accept at edge k, then WE high in cycle k..k+1. Latency is 1 cycle.
- Load: accept at edge k, then o_Stall high from cycle k. Ack sampled at edge m (m ≥ k+1), then WE in cycle m..m+1 and o_Stall low in that same cycle.
- Ack in the same cycle as the load is presented (before accept) is ignored. The memory must ack no earlier than the cycle after accept.
- ci_Valid while o_Stall = 1 is not accepted. Upstream must hold its inputs stable.

## Structure
- Shared package qm_pkg holds:
  - the state enum {IDLE, LOAD_WAIT, WRITE}
  - constants QM_WSRC_ALU = 0, QM_WSRC_MEM = 1
  - constants QM_DEST_RT = 0, QM_DEST_RD = 1
- No sub-module. The counter and destination mux are inline.
- The decode stage is unchanged: do_WA/do_WE/do_WD connect directly to its di_WA/di_WE/di_WD.

## Test plan
- Reset check: hold reset_n low with random inputs. All outputs read 0 and state is IDLE. Release reset, then drive ci_Valid=0 for 5 cycles: do_WE stays 0 and o_Retired stays 0.
- ALU op: ci_RegWrite=1, RegWSource=0, RegDest=1, di_RD=5, di_ALUResult=0xDEADBEEF. Next cycle do_WE=1, do_WA=5, do_WD=0xDEADBEEF, and o_Retired becomes 1 afterwards.
- Back-to-back ALU ops: four ops to RT=1..4 with results 0x10..0x13. Four consecutive WE cycles with matching WA/WD, o_Stall never asserted, o_Retired=4.
- Load with 3-cycle ack delay: RegWSource=1, di_RT=9, di_MemData=0x12345678 on ack. o_Stall high for 3 cycles, then one WE cycle with WA=9, WD=0x12345678. A second instruction presented during the stall is accepted only after o_Stall drops.
- $0 suppression: ALU op with RegDest=0, di_RT=0, result 0xFFFFFFFF. do_WE stays 0 and o_Retired still increments.
- Reset mid-load: assert reset_n low during LOAD_WAIT, then send an ack after release. No WE pulse and o_Retired=0. Separately, preload the counter path to 2^RETIRE_WIDTH-1 (RETIRE_WIDTH=4, 15 ops); the 16th op wraps o_Retired to 0.
